// File: rtl/sram_like_slave_pkg.sv
// Shared types and constants for the sram-like responder: response queue entry,
// countdown width and the stall LFSR.
package sram_like_slave_pkg;

    localparam int CNT_W = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic             wr;
        logic [31:0]      rdata;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[0] ^ cur[2] ^ cur[3] ^ cur[5], cur[15:1]};
    endfunction

endpackage

// File: rtl/sram_like_slave_resp_queue.sv
// In-order response FIFO in which every entry counts down its remaining latency;
// the head is released once its own countdown has expired.
module sram_like_slave_resp_queue
    import sram_like_slave_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             push_wr,
    input  logic [31:0]      push_rdata,
    input  logic [CNT_W-1:0] push_cnt,
    input  logic             pop,
    output logic             full,
    output logic             head_ready,
    output logic             head_wr,
    output logic [31:0]      head_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Slots outside the live window also tick down; they are overwritten on push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == PTR_W'(i)) begin
                entries[i] <= '{wr: push_wr, rdata: push_rdata, cnt: push_cnt};
            end else if (entries[i].cnt != '0) begin
                entries[i].cnt <= entries[i].cnt - CNT_W'(1);
            end
        end
    end

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign head_ready = (count != '0) && (entries[rd_ptr].cnt == '0);
    assign head_wr    = entries[rd_ptr].wr;
    assign head_rdata = entries[rd_ptr].rdata;

endmodule

// File: rtl/sram_like_slave.sv
// Responder for the CPU sram-like bus: word memory, optional random address stalls
// and an in-order, fixed-latency response path.
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int IDX_W      = 16,
    parameter int DATA_LAT   = 2,
    parameter int MAX_OUTST  = 4,
    parameter bit RAND_STALL = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(DATA_LAT - 1);

    logic [31:0]      mem [2**IDX_W];
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic             resetn_q;
    logic [15:0]      lfsr;
    logic             stall_ok;
    logic             full;
    logic             accept;
    logic             head_ready;
    logic             head_wr;
    logic [31:0]      head_rdata;
    logic             unused_bits;

    assign idx         = addr[IDX_W+1:2];
    assign rd_word     = mem[idx];
    assign unused_bits = ^{size, addr[31:IDX_W+2], addr[1:0]};

    assign stall_ok = RAND_STALL ? lfsr[0] : 1'b1;
    assign addr_ok  = !full && stall_ok && resetn_q;
    assign accept   = req && addr_ok && resetn;

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Registered response: the head entry pops on the same edge that raises data_ok.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            lfsr     <= LFSR_SEED;
            data_ok  <= 1'b0;
            rdata    <= '0;
        end else begin
            resetn_q <= 1'b1;
            lfsr     <= lfsr_next(lfsr);
            data_ok  <= head_ready;
            rdata    <= (head_ready && !head_wr) ? head_rdata : '0;
        end
    end

    sram_like_slave_resp_queue #(
        .DEPTH(MAX_OUTST)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_wr    (wr),
        .push_rdata (wr ? 32'h0 : rd_word),
        .push_cnt   (START_CNT),
        .pop        (head_ready),
        .full       (full),
        .head_ready (head_ready),
        .head_wr    (head_wr),
        .head_rdata (head_rdata)
    );

endmodule
